ex_mem: RTL

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. It captures the execute stage's result, register-write, and HI/LO-write fields on each clock and presents them to the memory-access stage. It honours the global stall vector and flush, inserting bubbles where required. It also holds the 64-bit intermediate product and cycle counter that let the execute stage run two-cycle `madd`/`maddu`/`msub`/`msubu` instructions while stalled.

---
 rtl/ex_mem_pkg.sv | 18 +
 rtl/ex_mem_if.sv | 34 +++
 rtl/ex_mem.sv | 60 ++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared widths and constants for the EX/MEM pipeline register.
// Mirrors the core-wide definitions so every stage agrees on bus sizes.
package ex_mem_pkg;

    localparam int RegDataBus   = 32;
    localparam int RegAddrBus   = 5;
    localparam int DoubleRegBus = 64;
    localparam int StallBus     = 6;
    localparam int CntBus       = 2;

    // Positions in the global stall vector {wb, mem, ex, id, if, pc}
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam logic                  Disable   = 1'b0;
    localparam logic [RegAddrBus-1:0] RegAddr_0 = '0;

endpackage

// File: rtl/ex_mem_if.sv
// Bundle of execute-side inputs and memory-side outputs of the EX/MEM register.
// master = execute stage view, slave = the pipeline register itself.
interface ex_mem_if;
    import ex_mem_pkg::*;

    logic [RegDataBus-1:0]   ex_result;
    logic [RegAddrBus-1:0]   ex_waddr;
    logic                    ex_we;
    logic [RegDataBus-1:0]   ex_hi;
    logic [RegDataBus-1:0]   ex_lo;
    logic                    ex_whilo;
    logic [DoubleRegBus-1:0] hilo_temp_i;
    logic [CntBus-1:0]       cnt_i;

    logic [RegDataBus-1:0]   mem_result;
    logic [RegAddrBus-1:0]   mem_waddr;
    logic                    mem_we;
    logic [RegDataBus-1:0]   mem_hi;
    logic [RegDataBus-1:0]   mem_lo;
    logic                    mem_whilo;
    logic [DoubleRegBus-1:0] hilo_temp_o;
    logic [CntBus-1:0]       cnt_o;

    modport master (
        output ex_result, ex_waddr, ex_we, ex_hi, ex_lo, ex_whilo, hilo_temp_i, cnt_i,
        input  mem_result, mem_waddr, mem_we, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o
    );

    modport slave (
        input  ex_result, ex_waddr, ex_we, ex_hi, ex_lo, ex_whilo, hilo_temp_i, cnt_i,
        output mem_result, mem_waddr, mem_we, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o
    );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: flush > bubble/advance/hold, plus the multiply-accumulate
// scratch state (hilo_temp/cnt) that survives while execute is stalled.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [StallBus-1:0] stall,
    input  logic                flush,
    ex_mem_if.slave             bus
);

    // Only the ex and mem stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_result  <= '0;
            bus.mem_waddr   <= RegAddr_0;
            bus.mem_we      <= Disable;
            bus.mem_hi      <= '0;
            bus.mem_lo      <= '0;
            bus.mem_whilo   <= Disable;
            bus.hilo_temp_o <= '0;
            bus.cnt_o       <= '0;
        end else if (flush) begin
            bus.mem_result  <= '0;
            bus.mem_waddr   <= RegAddr_0;
            bus.mem_we      <= Disable;
            bus.mem_hi      <= '0;
            bus.mem_lo      <= '0;
            bus.mem_whilo   <= Disable;
            bus.hilo_temp_o <= '0;
            bus.cnt_o       <= '0;
        end else if (!stall[STALL_EX]) begin
            // Advance; a mem-only stall cannot happen legally and is treated the same way.
            bus.mem_result  <= bus.ex_result;
            bus.mem_waddr   <= bus.ex_waddr;
            bus.mem_we      <= bus.ex_we;
            bus.mem_hi      <= bus.ex_hi;
            bus.mem_lo      <= bus.ex_lo;
            bus.mem_whilo   <= bus.ex_whilo;
            bus.hilo_temp_o <= '0;
            bus.cnt_o       <= '0;
        end else if (!stall[STALL_MEM]) begin
            // Bubble downstream while keeping execute's partial product alive.
            bus.mem_result  <= '0;
            bus.mem_waddr   <= RegAddr_0;
            bus.mem_we      <= Disable;
            bus.mem_hi      <= '0;
            bus.mem_lo      <= '0;
            bus.mem_whilo   <= Disable;
            bus.hilo_temp_o <= bus.hilo_temp_i;
            bus.cnt_o       <= bus.cnt_i;
        end
        // Both ex and mem stalled: hold every register.
    end

endmodule
